// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared widths, types and bypass helpers for the operand fetch stage
package operand_fetch_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_NUM = 32;
  localparam int IDX_W   = $clog2(REG_NUM);
  localparam int CTRL_W  = 16;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  creg_addr_t;
  typedef logic [CTRL_W-1:0] ctrl_t;

  // One writer stage as seen from operand fetch.
  typedef struct packed {
    logic       valid;
    logic       is_load;
    logic       data_ok;
    creg_addr_t wid;
    word_t      wdata;
  } bypass_t;

  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

  // Stage writes the register being read.
  function automatic logic bp_match(input bypass_t s, input creg_addr_t idx);
    return s.valid && (s.wid == idx);
  endfunction

  // Stage result is usable this cycle (non-load, or load with data back).
  function automatic logic bp_ready(input bypass_t s);
    return !s.is_load || s.data_ok;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - decode-side and execute-side handshakes of the operand fetch stage
interface operand_fetch_if;
  import operand_fetch_pkg::*;

  logic       in_valid;
  logic       in_ready;
  creg_addr_t in_ra1;
  creg_addr_t in_ra2;
  logic       in_use1;
  logic       in_use2;
  creg_addr_t in_rd;
  ctrl_t      in_ctrl;

  logic       out_valid;
  logic       out_ready;
  word_t      out_src1;
  word_t      out_src2;
  creg_addr_t out_rd;
  ctrl_t      out_ctrl;

  modport master (
    output in_valid, in_ra1, in_ra2, in_use1, in_use2, in_rd, in_ctrl, out_ready,
    input  in_ready, out_valid, out_src1, out_src2, out_rd, out_ctrl
  );

  modport slave (
    input  in_valid, in_ra1, in_ra2, in_use1, in_use2, in_rd, in_ctrl, out_ready,
    output in_ready, out_valid, out_src1, out_src2, out_rd, out_ctrl
  );

endinterface

// File: rtl/operand_fetch_bypass.sv
// rtl/operand_fetch_bypass.sv - per-source bypass mux and load-use hazard detect
module operand_bypass
  import operand_fetch_pkg::*;
(
  input  creg_addr_t idx,
  input  logic       use_src,
  input  word_t      rf_data,
  input  bypass_t    ex,
  input  bypass_t    mem,
  input  bypass_t    wb,
  output word_t      value,
  output logic       hazard
);

  logic nz;
  logic ex_fwd, mem_fwd, wb_fwd;
  logic ex_wait, mem_wait, wb_wait;

  // Youngest ready writer wins; a pending load is skipped for the value
  // and raises a hazard unless a younger ready writer already covers it.
  always_comb begin
    nz       = (idx != '0);
    ex_fwd   = bp_match(ex, idx)  && bp_ready(ex);
    mem_fwd  = bp_match(mem, idx) && bp_ready(mem);
    wb_fwd   = bp_match(wb, idx)  && bp_ready(wb);
    ex_wait  = bp_match(ex, idx)  && !bp_ready(ex);
    mem_wait = bp_match(mem, idx) && !bp_ready(mem);
    wb_wait  = bp_match(wb, idx)  && !bp_ready(wb);

    value = rf_data;
    if (!nz)          value = '0;
    else if (ex_fwd)  value = ex.wdata;
    else if (mem_fwd) value = mem.wdata;
    else if (wb_fwd)  value = wb.wdata;

    hazard = use_src && nz &&
             (ex_wait ||
              (mem_wait && !ex_fwd) ||
              (wb_wait && !ex_fwd && !mem_fwd));
  end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register read stage with bypassing, load-use interlock and output slot
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  operand_fetch_if.slave bus,
  output creg_addr_t  rf_ra1,
  output creg_addr_t  rf_ra2,
  input  word_t       rf_src1,
  input  word_t       rf_src2,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  creg_addr_t  ex_wid,
  input  word_t       ex_wdata,
  input  logic        mem_valid,
  input  logic        mem_is_load,
  input  logic        mem_data_ok,
  input  creg_addr_t  mem_wid,
  input  word_t       mem_wdata,
  input  logic        wb_valid,
  input  creg_addr_t  wb_wid,
  input  word_t       wb_wdata,
  input  logic        flush,
  output logic [31:0] stall_cnt
);

  bypass_t ex_bp, mem_bp, wb_bp;
  word_t   res1, res2;
  logic    haz1, haz2, hazard, capture;

  logic        valid_q;
  word_t       src1_q, src2_q;
  creg_addr_t  rd_q;
  ctrl_t       ctrl_q;
  logic [31:0] stall_q;

  // EX results never come from a completed load; WB data is always final.
  assign ex_bp  = '{valid: ex_valid,  is_load: ex_is_load,  data_ok: 1'b0,
                    wid: ex_wid,  wdata: ex_wdata};
  assign mem_bp = '{valid: mem_valid, is_load: mem_is_load, data_ok: mem_data_ok,
                    wid: mem_wid, wdata: mem_wdata};
  assign wb_bp  = '{valid: wb_valid,  is_load: 1'b0,        data_ok: 1'b1,
                    wid: wb_wid,  wdata: wb_wdata};

  assign rf_ra1 = bus.in_ra1;
  assign rf_ra2 = bus.in_ra2;

  operand_bypass u_byp1 (
    .idx(bus.in_ra1), .use_src(bus.in_use1), .rf_data(rf_src1),
    .ex(ex_bp), .mem(mem_bp), .wb(wb_bp), .value(res1), .hazard(haz1)
  );

  operand_bypass u_byp2 (
    .idx(bus.in_ra2), .use_src(bus.in_use2), .rf_data(rf_src2),
    .ex(ex_bp), .mem(mem_bp), .wb(wb_bp), .value(res2), .hazard(haz2)
  );

  assign hazard       = haz1 || haz2;
  assign bus.in_ready = !hazard && !flush && (!valid_q || bus.out_ready);
  assign capture      = bus.in_valid && bus.in_ready;

  // Output slot: flush squashes, capture replaces, a drained slot empties.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      src1_q  <= res1;
      src2_q  <= res2;
      rd_q    <= bus.in_rd;
      ctrl_q  <= bus.in_ctrl;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Count cycles a real instruction is held back by a load-use hazard.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
    end else if (bus.in_valid && hazard && !flush && (stall_q != STALL_MAX)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_src1  = src1_q;
  assign bus.out_src2  = src2_q;
  assign bus.out_rd    = rd_q;
  assign bus.out_ctrl  = ctrl_q;
  assign stall_cnt     = stall_q;

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Register-read stage between decode and execute.
- Drives the regfile read addresses and receives the regfile read data.
- Applies bypassing from EX, MEM and WB, and interlocks on load-use hazards.
- Holds a registered decode-to-execute pipeline slot with a valid/ready handshake, plus a saturating stall-cycle counter for performance analysis.

Parameters:
- DATA_W, 32: data word width.
- REG_NUM, 32: architectural register count. Register index width is clog2(REG_NUM).
- CTRL_W, 16: width of the opaque decoded-control bundle carried alongside the operands.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous reset, active low.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the decoded instruction this cycle.
- in_ra1, in_ra2  in  IDX_W each  source register indices.
- in_use1, in_use2  in  1 each  source actually read by the instruction.
- in_rd  in  IDX_W  destination index.
- in_ctrl  in  CTRL_W  decoded control bundle.
- rf_ra1, rf_ra2  out  IDX_W each  regfile read addresses (combinational copy of in_ra1/in_ra2).
- rf_src1, rf_src2  in  DATA_W each  regfile read data (combinational; 0 for index 0).
- ex_valid  in  1  EX slot holds a writing instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_wid  in  IDX_W  EX destination index.
- ex_wdata  in  DATA_W  EX result.
- mem_valid  in  1  MEM slot holds a writing instruction.
- mem_is_load  in  1  MEM instruction is a load.
- mem_data_ok  in  1  MEM load data is ready this cycle.
- mem_wid  in  IDX_W  MEM destination index.
- mem_wdata  in  DATA_W  MEM result.
- wb_valid, wb_wid, wb_wdata  in  1/IDX_W/DATA_W  same triple as the regfile write port.
- flush  in  1  squash the held slot and the incoming instruction.
- out_valid  out  1  registered slot valid toward execute.
- out_ready  in  1  execute accepts the slot.
- out_src1, out_src2  out  DATA_W each  resolved operands.
- out_rd  out  IDX_W  destination index.
- out_ctrl  out  CTRL_W  control bundle.
- stall_cnt  out  32  saturating count of hazard-stall cycles.

Behaviour:
- Reset (resetn low, asynchronous):
  - out_valid=0; out_src1, out_src2, out_rd, out_ctrl = 0; stall_cnt=0.
  - in_ready may be 1 while reset is held, but nothing is captured.
- Operand resolution, per source, combinational:
  - Index 0 always yields 0 and is never bypassed.
  - Otherwise the first match in priority order wins: EX (ex_valid && ex_wid==ra && !ex_is_load) → MEM (mem_valid && mem_wid==ra, using mem_wdata; a load qualifies only when mem_data_ok) → WB (wb_valid && wb_wid==ra) → rf_srcN.
  - The WB bypass is required because the regfile updates only at the clock edge.
- Hazard (combinational, evaluated only for sources with in_useN=1 and index≠0):
  - EX load whose ex_wid matches a used source.
  - MEM load with !mem_data_ok whose mem_wid matches a used source, unless a younger EX non-load also matches that source.
- Handshake and slot update:
  - in_ready = !hazard && !flush && (!out_valid || out_ready).
  - Capture on in_valid && in_ready. Resolved operands, in_rd and in_ctrl are registered and out_valid=1 on the next edge: 1-cycle latency.
  - out_valid && out_ready with no capture → out_valid=0 next edge.
  - Both in the same cycle → slot replaced (back-to-back throughput 1/cycle).
  - While out_valid && !out_ready, all out_* hold stable.
- flush:
  - flush=1 → out_valid=0 on the next edge and no capture that cycle.
  - flush dominates hazard and handshake.
  - Payload registers may keep stale values.
- stall_cnt:
  - Increments by 1 each cycle with in_valid && hazard && !flush.
  - Saturates at 32'hFFFF_FFFF.
- Boundary cases:
  - Duplicate sources (ra1==ra2) resolve identically.
  - The same register matching in EX and MEM takes EX.
  - Operand values are sampled in the capture cycle only and never re-read while held.

Decomposition:
- Shared package common: IDX_W, word_t, creg_addr_t, and a bypass_t struct {valid, is_load, data_ok, wid, wdata}. The EX, MEM and WB ports each use it; EX ties data_ok=0 and WB ties is_load=0, data_ok=1.
- One sub-module, operand_bypass: pure combinational, instantiated twice. Inputs: index, use, rf data, three bypass_t. Outputs: resolved value and hazard bit.

Test Plan:
- Reset then single instruction: ra1=3, ra2=4, rf gives 0x11/0x22, no bypass, out_ready=1 → out_valid=1 after 1 cycle with src1=0x11, src2=0x22; stall_cnt=0.
- Priority: ex(wid=5, 0xAAAA, non-load), mem(wid=5, 0xBBBB), wb(wid=5, 0xCCCC), ra1=5 → src1=0xAAAA. Removing EX gives 0xBBBB; removing MEM as well gives 0xCCCC.
- Load-use: ex_is_load, wid=7, ra1=7, in_use1=1 → in_ready=0 for 1 cycle, stall_cnt=1. Next cycle MEM load with data_ok=1, data 0x1234 → captured src1=0x1234.
- Index 0: ra1=0 while ex_wid=0 ex_valid → src1=0 and no stall. Same with in_use1=0 and ex load wid=9, ra1=9 → no stall.
- Backpressure: out_ready=0 for 3 cycles with a held slot → out_* stable and in_ready=0. Then out_ready=1 with a new in_valid → next slot follows with no bubble.
- flush with out_valid=1 and in_valid=1 → out_valid=0 next cycle and nothing captured. Also drive hazard for 2^32+ cycles via a forced counter preload → stall_cnt stays 0xFFFF_FFFF.
